// File: rtl/seven_segment_decoder.sv
// Registered BCD-to-seven-segment decoder for one common-cathode digit.
// Supports lamp test, blanking and ripple-blanking (leading-zero suppression).
// Illegal codes 10-15 are flagged on err and shown as a dark digit.
// Every output is a direct flop output, so the segment lines never glitch.
module seven_segment_decoder (
    input  logic clk,
    input  logic rst,
    input  logic w,
    input  logic x,
    input  logic y,
    input  logic z,
    input  logic lt,
    input  logic bl,
    input  logic rbi,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic rbo,
    output logic err
);

    // Segment vectors are ordered {a, b, c, d, e, f, g}.
    localparam logic [6:0] SegOff = 7'b000_0000;
    localparam logic [6:0] SegAll = 7'b111_1111;

    logic [3:0] w_code;
    logic       w_illegal;
    logic       w_zero;
    logic [6:0] w_decode;
    logic [6:0] w_seg_next;
    logic       w_rbo_next;

    logic [6:0] r_seg;
    logic       r_rbo;
    logic       r_err;

    assign w_code = {w, x, y, z};

    // Classify the incoming code: illegal (10-15) and zero.
    always_comb begin
        w_illegal = (w_code > 4'd9);
        w_zero    = (w_code == 4'd0);
    end

    // Raw BCD decode; illegal codes show nothing.
    always_comb begin
        w_decode = SegOff;
        case (w_code)
            4'd0:    w_decode = 7'b111_1110;
            4'd1:    w_decode = 7'b011_0000;
            4'd2:    w_decode = 7'b110_1101;
            4'd3:    w_decode = 7'b111_1001;
            4'd4:    w_decode = 7'b011_0011;
            4'd5:    w_decode = 7'b101_1011;
            4'd6:    w_decode = 7'b101_1111;
            4'd7:    w_decode = 7'b111_0000;
            4'd8:    w_decode = 7'b111_1111;
            4'd9:    w_decode = 7'b111_1011;
            default: w_decode = SegOff;
        endcase
    end

    // Override priority: lamp test, then blank, then ripple blank, then decode.
    always_comb begin
        w_seg_next = w_decode;
        w_rbo_next = 1'b0;
        if (lt) begin
            w_seg_next = SegAll;
        end else if (bl) begin
            w_seg_next = SegOff;
        end else if (rbi && w_zero) begin
            // Suppressed zero: tell the next less-significant digit to blank its zero too.
            w_seg_next = SegOff;
            w_rbo_next = 1'b1;
        end
    end

    // Output registers; reset clears the display immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= SegOff;
            r_rbo <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_seg <= w_seg_next;
            r_rbo <= w_rbo_next;
            r_err <= w_illegal;
        end
    end

    assign {a, b, c, d, e, f, g} = r_seg;
    assign rbo = r_rbo;
    assign err = r_err;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder.
module tb_seven_segment_decoder;

    logic clk;
    logic rst;
    logic w, x, y, z;
    logic lt, bl, rbi;
    logic a, b, c, d, e, f, g;
    logic rbo, err;
    logic [6:0] seg;

    int errors;
    int checks;

    assign seg = {a, b, c, d, e, f, g};

    seven_segment_decoder dut (
        .clk (clk),
        .rst (rst),
        .w   (w),
        .x   (x),
        .y   (y),
        .z   (z),
        .lt  (lt),
        .bl  (bl),
        .rbi (rbi),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .g   (g),
        .rbo (rbo),
        .err (err)
    );

    // 178 ns clock period: one code per window.
    initial clk = 1'b0;
    always #89 clk = ~clk;

    task automatic set_in(input logic [3:0] code, input logic l, input logic bk, input logic r);
        {w, x, y, z} = code;
        lt  = l;
        bl  = bk;
        rbi = r;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Outputs held clear from time zero while rst is high.
        checks++;
        if (seg !== 7'b000_0000 || rbo !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: seg=%b rbo=%b err=%b, want 0000000 0 0", seg, rbo, err);
        end
        set_in(4'd8, 1'b1, 1'b0, 1'b0);
        tick();
        #20 rst = 1'b0;
        tick();
        checks++;
        if (seg !== 7'b111_1111) begin
            errors++;
            $display("FAIL reset_release_lt: seg=%b want 1111111", seg);
        end
        // Assert reset between edges: must clear without a clock edge.
        #30 rst = 1'b1;
        #1;
        checks++;
        if (seg !== 7'b000_0000 || rbo !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: seg=%b rbo=%b err=%b, want 0000000 0 0", seg, rbo, err);
        end
        tick();
        checks++;
        if (seg !== 7'b000_0000) begin
            errors++;
            $display("FAIL reset_held: seg=%b want 0000000", seg);
        end
        #20 rst = 1'b0;
        tick();
        checks++;
        if (seg !== 7'b111_1111) begin
            errors++;
            $display("FAIL reset_resume: seg=%b want 1111111", seg);
        end
    endtask

    task automatic test_decode_sweep();
        logic [6:0] exp_tab [10];
        exp_tab[0] = 7'b111_1110;
        exp_tab[1] = 7'b011_0000;
        exp_tab[2] = 7'b110_1101;
        exp_tab[3] = 7'b111_1001;
        exp_tab[4] = 7'b011_0011;
        exp_tab[5] = 7'b101_1011;
        exp_tab[6] = 7'b101_1111;
        exp_tab[7] = 7'b111_0000;
        exp_tab[8] = 7'b111_1111;
        exp_tab[9] = 7'b111_1011;
        for (int i = 0; i < 10; i++) begin
            set_in(4'(i), 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (seg !== exp_tab[i] || err !== 1'b0 || rbo !== 1'b0) begin
                errors++;
                $display("FAIL decode_%0d: seg=%b err=%b rbo=%b, want %b 0 0",
                         i, seg, err, rbo, exp_tab[i]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 10; i < 16; i++) begin
            set_in(4'(i), 1'b0, 1'b0, 1'b0);
            tick();
            checks++;
            if (seg !== 7'b000_0000 || err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d: seg=%b err=%b, want 0000000 1", i, seg, err);
            end
        end
        // err is independent of the overrides.
        set_in(4'd12, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b111_1111 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_lt: seg=%b err=%b, want 1111111 1", seg, err);
        end
        set_in(4'd10, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if (seg !== 7'b000_0000 || err !== 1'b1 || rbo !== 1'b0) begin
            errors++;
            $display("FAIL illegal_bl: seg=%b err=%b rbo=%b, want 0000000 1 0", seg, err, rbo);
        end
        set_in(4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b111_1001 || err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_recover: seg=%b err=%b, want 1111001 0", seg, err);
        end
    endtask

    task automatic test_priority();
        set_in(4'd5, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b111_1111 || rbo !== 1'b0) begin
            errors++;
            $display("FAIL prio_lt_over_bl: seg=%b rbo=%b, want 1111111 0", seg, rbo);
        end
        set_in(4'd5, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b000_0000) begin
            errors++;
            $display("FAIL prio_bl: seg=%b want 0000000", seg);
        end
        set_in(4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b101_1011) begin
            errors++;
            $display("FAIL prio_none: seg=%b want 1011011", seg);
        end
        // Lamp test beats ripple blank; blank beats ripple blank and suppresses rbo.
        set_in(4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++;
        if (seg !== 7'b111_1111 || rbo !== 1'b0) begin
            errors++;
            $display("FAIL prio_lt_over_rbi: seg=%b rbo=%b, want 1111111 0", seg, rbo);
        end
        set_in(4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if (seg !== 7'b000_0000 || rbo !== 1'b0) begin
            errors++;
            $display("FAIL prio_bl_over_rbi: seg=%b rbo=%b, want 0000000 0", seg, rbo);
        end
    endtask

    task automatic test_ripple();
        set_in(4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (seg !== 7'b000_0000 || rbo !== 1'b1) begin
            errors++;
            $display("FAIL ripple_zero: seg=%b rbo=%b, want 0000000 1", seg, rbo);
        end
        set_in(4'd7, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (seg !== 7'b111_0000 || rbo !== 1'b0) begin
            errors++;
            $display("FAIL ripple_nonzero: seg=%b rbo=%b, want 1110000 0", seg, rbo);
        end
        set_in(4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b111_1110 || rbo !== 1'b0) begin
            errors++;
            $display("FAIL ripple_off_zero: seg=%b rbo=%b, want 1111110 0", seg, rbo);
        end
    endtask

    task automatic test_latency();
        set_in(4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b011_0000) begin
            errors++;
            $display("FAIL latency_base: seg=%b want 0110000", seg);
        end
        // Input changes mid-window must not reach the outputs before the edge.
        #40 set_in(4'd2, 1'b0, 1'b0, 1'b0);
        #40 set_in(4'd4, 1'b0, 1'b0, 1'b0);
        #40;
        checks++;
        if (seg !== 7'b011_0000) begin
            errors++;
            $display("FAIL latency_hold: seg=%b want 0110000", seg);
        end
        tick();
        checks++;
        if (seg !== 7'b011_0011) begin
            errors++;
            $display("FAIL latency_update: seg=%b want 0110011", seg);
        end
        // Back-to-back codes, one per cycle.
        set_in(4'd6, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(4'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if (seg !== 7'b101_1111) begin
            errors++;
            $display("FAIL back_to_back_6: seg=%b want 1011111", seg);
        end
        tick();
        checks++;
        if (seg !== 7'b111_1011) begin
            errors++;
            $display("FAIL back_to_back_9: seg=%b want 1111011", seg);
        end
        // Reset mid-window clears at once; pending input is not retained.
        set_in(4'd8, 1'b0, 1'b0, 1'b0);
        #50 rst = 1'b1;
        #1;
        checks++;
        if (seg !== 7'b000_0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL latency_async_rst: seg=%b err=%b, want 0000000 0", seg, err);
        end
        #20 rst = 1'b0;
        set_in(4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (seg !== 7'b110_1101) begin
            errors++;
            $display("FAIL latency_after_rst: seg=%b want 1101101", seg);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        set_in(4'd8, 1'b1, 1'b0, 1'b0);
        #5;
        test_reset();
        test_decode_sweep();
        test_illegal();
        test_priority();
        test_ripple();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
